// File: rtl/clock_pkg.sv
// Shared clock/calendar definitions.
//   TIME_W        : width of the hr/min/sec fields
//   MAX_SEC/MIN/HR: last legal value of each field before it wraps
//   BTN_*         : button bit positions for the set-mode actions
//   split_digits  : binary value -> {tens, ones} BCD digits (also used by mmdd)
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] MAX_SEC = TIME_W'(59);
  localparam logic [TIME_W-1:0] MAX_MIN = TIME_W'(59);
  localparam logic [TIME_W-1:0] MAX_HR  = TIME_W'(23);

  localparam int BTN_MIN    = 0;
  localparam int BTN_HR     = 1;
  localparam int BTN_SECCLR = 2;

  // Returns {tens[3:0], ones[3:0]}; values stay below 64 so tens fits 4 bits.
  function automatic logic [7:0] split_digits(input logic [TIME_W-1:0] v);
    return {4'(v / TIME_W'(10)), 4'(v % TIME_W'(10))};
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button conditioning: two-flop synchronizer per bit plus a history flop,
// producing a one-cycle pulse on each synchronized rising edge.
//   clk    : system clock
//   rst    : synchronous active-high reset, clears all flops
//   btn_i  : raw asynchronous buttons
//   edge_o : rising-edge pulses (s2 & ~s3), high for one cycle per press
module btn_edge_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] edge_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // A held button keeps s3 high, so it yields a single pulse until released.
  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/time_counter.sv
// 24-hour time-of-day keeper feeding the calendar date stage.
//   clk, rst        : system clock, synchronous active-high reset
//   sw1             : 1 = time-set mode (counting halted), 0 = run
//   btn[3:0]        : raw buttons; in set mode bit0 min+1, bit1 hr+1, bit2 sec=0
//   hr, min, sec    : binary time fields
//   tick            : one-cycle 1 Hz strobe (drives mmdd enb)
//   hr1/hr2, mn1/mn2, sc1/sc2 : tens/ones digits of each field
module time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw1,
  input  logic [3:0]        btn,
  output logic [TIME_W-1:0] hr,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              tick,
  output logic [3:0]        hr1,
  output logic [3:0]        hr2,
  output logic [3:0]        mn1,
  output logic [3:0]        mn2,
  output logic [3:0]        sc1,
  output logic [3:0]        sc2
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIME_W-1:0]  hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [3:0]         btn_edge;
  logic               one_hot;
  logic               presc_last;

  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction

  btn_edge_sync #(.W(4)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .edge_o (btn_edge)
  );

  // Simultaneous presses are ambiguous, so only a single-bit edge acts.
  assign one_hot    = (btn_edge != 4'd0) && ((btn_edge & (btn_edge - 4'd1)) == 4'd0);
  assign presc_last = (presc_q == PRESC_LAST);
  assign tick       = presc_last & ~sw1 & ~rst;

  always_comb begin
    presc_d = presc_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;

    // Set mode pins the prescaler at 0 so a full second elapses after leaving it.
    if (sw1 || presc_last) presc_d = '0;
    else                   presc_d = presc_q + 1'b1;

    if (sw1) begin
      if (one_hot) begin
        if (btn_edge[BTN_MIN])    min_d = inc_wrap(min_q, MAX_MIN);
        if (btn_edge[BTN_HR])     hr_d  = inc_wrap(hr_q, MAX_HR);
        if (btn_edge[BTN_SECCLR]) sec_d = '0;
      end
    end else if (tick) begin
      sec_d = inc_wrap(sec_q, MAX_SEC);
      if (sec_q == MAX_SEC) begin
        min_d = inc_wrap(min_q, MAX_MIN);
        if (min_q == MAX_MIN) hr_d = inc_wrap(hr_q, MAX_HR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign hr  = hr_q;
  assign min = min_q;
  assign sec = sec_q;

  assign {hr1, hr2} = split_digits(hr_q);
  assign {mn1, mn2} = split_digits(min_q);
  assign {sc1, sc2} = split_digits(sec_q);

endmodule
